fifo_word_serializer: RTL and testbench

FIFO_WORD_SERIALIZER -- requirements
Module: fifo_word_serializer

---
 rtl/fifo_ser_pkg.sv | 32 +++
 rtl/fifo_word_serializer_bit_timer.sv | 27 ++
 rtl/fifo_word_serializer.sv | 120 ++++++++++++
 tb/tb_fifo_word_serializer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ser_pkg.sv
// Shared encodings and frame constants for fifo_word_serializer.
// FIFO_SER_PARITY_EN adds an even-parity bit between the data bits and the stop bit.
package fifo_ser_pkg;

    localparam int DEFAULT_BIT_DIV = 4;
    localparam int DEFAULT_WIDTH   = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_WAIT   = 3'd2,
        ST_START  = 3'd3,
        ST_DATA   = 3'd4,
        ST_PARITY = 3'd5,
        ST_STOP   = 3'd6
    } state_t;

`ifdef FIFO_SER_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    // Start + stop, plus the optional parity bit.
    localparam int FRAME_OVERHEAD = 2 + PARITY_BITS;
    localparam int FRAME_BITS     = DEFAULT_WIDTH + FRAME_OVERHEAD;

    function automatic int frame_bits(input int width);
        return width + FRAME_OVERHEAD;
    endfunction

endpackage

// File: rtl/fifo_word_serializer_bit_timer.sv
// Bit-period down-counter: tick is high in the last cycle of each BIT_DIV-cycle period.
module bit_timer
    import fifo_ser_pkg::*;
#(
    parameter int BIT_DIV = DEFAULT_BIT_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 8'd0;
        end else if (restart) begin
            count <= 8'(BIT_DIV - 1);
        end else if (count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign tick = (count == 8'd0);

endmodule

// File: rtl/fifo_word_serializer.sv
// Pulls words from an upstream FIFO and sends them LSB first as start/data/stop frames.
// Define FIFO_SER_PARITY_EN to insert an even-parity bit before the stop bit.
module fifo_word_serializer
    import fifo_ser_pkg::*;
#(
    parameter int BIT_DIV = DEFAULT_BIT_DIV,
    parameter int WIDTH   = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tx_enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             fifo_read,
    output logic             ser_out,
    output logic             busy,
    output logic             frame_done,
    output logic [7:0]       frame_count,
    output logic [2:0]       debug_state
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, next_state;
    logic             tick, restart;
    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    bit_cnt;
    logic             last_bit;

    assign last_bit    = (bit_cnt == CW'(WIDTH - 1));
    assign debug_state = state;

    // The timer reloads on every state entry and at each DATA bit boundary.
    assign restart = (next_state != state) || ((state == ST_DATA) && tick);

    bit_timer #(.BIT_DIV(BIT_DIV)) u_bit_timer (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (tx_enable && !fifo_empty) next_state = ST_REQ;
            ST_REQ:   next_state = ST_WAIT;
            ST_WAIT:  next_state = ST_START;
            ST_START: if (tick) next_state = ST_DATA;
`ifdef FIFO_SER_PARITY_EN
            ST_DATA:   if (tick && last_bit) next_state = ST_PARITY;
            ST_PARITY: if (tick) next_state = ST_STOP;
`else
            ST_DATA:  if (tick && last_bit) next_state = ST_STOP;
`endif
            ST_STOP:  if (tick) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

`ifdef FIFO_SER_PARITY_EN
    logic parity_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            parity_bit <= 1'b0;
        end else if (state == ST_WAIT) begin
            parity_bit <= ^fifo_dout;
        end
    end
`endif

    // FIFO handshake: fifo_read is high for the single REQ cycle; the FIFO samples it
    // on the following edge and presents the word on fifo_dout during WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg   <= '0;
            bit_cnt     <= '0;
            frame_count <= 8'd0;
        end else begin
            if (state == ST_WAIT) begin
                shift_reg <= fifo_dout;
                bit_cnt   <= '0;
            end else if ((state == ST_DATA) && tick) begin
                shift_reg <= shift_reg >> 1;
                bit_cnt   <= bit_cnt + CW'(1);
            end
            if ((state == ST_STOP) && tick) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end

    always_comb begin
        fifo_read  = 1'b0;
        busy       = 1'b1;
        ser_out    = 1'b1;
        frame_done = 1'b0;
        case (state)
            ST_IDLE:   busy = 1'b0;
            ST_REQ:    fifo_read = 1'b1;
            ST_START:  ser_out = 1'b0;
            ST_DATA:   ser_out = shift_reg[0];
`ifdef FIFO_SER_PARITY_EN
            ST_PARITY: ser_out = parity_bit;
`endif
            ST_STOP:   frame_done = tick;
            default:   ;
        endcase
    end

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Bench for fifo_word_serializer: a queue-backed FIFO model and a frame-level reference
// model predicting every output cycle by cycle. Honours FIFO_SER_PARITY_EN.
module tb_fifo_word_serializer;

    localparam int BIT_DIV = 4;
    localparam int WIDTH   = 16;
`ifdef FIFO_SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FB  = WIDTH + 2 + PAR;
    localparam int BIG = 1 << 30;

    logic             clk = 1'b0;
    logic             reset;
    logic             tx_enable;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_read;
    logic             ser_out;
    logic             busy;
    logic             frame_done;
    logic [7:0]       frame_count;
    logic [2:0]       debug_state;

    int tests       = 0;
    int failures    = 0;
    int rd_pulses   = 0;
    int busy_cycles = 0;
    int cyc         = 0;
    logic [7:0]       model_count = 8'd0;
    logic [WIDTH-1:0] fifo_q[$];

    fifo_word_serializer #(.BIT_DIV(BIT_DIV), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_enable   (tx_enable),
        .fifo_empty  (fifo_empty),
        .fifo_dout   (fifo_dout),
        .fifo_read   (fifo_read),
        .ser_out     (ser_out),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .debug_state (debug_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // One clock: the FIFO model pops on the edge that samples fifo_read.
    task automatic advance();
        logic rd_seen;
        rd_seen = fifo_read;
        if (fifo_read === 1'b1) rd_pulses++;
        if (busy === 1'b1) busy_cycles++;
        @(posedge clk);
        #1;
        cyc++;
        if (rd_seen === 1'b1 && fifo_q.size() != 0) fifo_dout = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic push_word(input logic [WIDTH-1:0] w);
        fifo_q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic clear_fifo();
        fifo_q.delete();
        fifo_empty = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        advance();
        advance();
        reset = 1'b0;
        model_count = 8'd0;
    endtask

    // ---------------- reference model + scoreboard ----------------
    // Called with the DUT idle in the current cycle and the FIFO model loaded.
    // Each word costs IDLE, REQ, WAIT, then FB bit periods of BIT_DIV cycles.
    task automatic run_frames(input int drop_at, input int tail);
        logic [WIDTH-1:0] words[$];
        logic       exp_q[$];
        logic       exp_rd_q[$];
        logic       exp_busy_q[$];
        logic       exp_done_q[$];
        logic [7:0] exp_cnt_q[$];
        logic [WIDTH-1:0] w;
        logic [7:0] cnt;
        logic bitval, last;
        int c;
        words = fifo_q;
        cnt = model_count;
        c = 0;
        while (words.size() != 0 && c < drop_at) begin
            w = words.pop_front();
            for (int p = 0; p < 3; p++) begin
                exp_q.push_back(1'b1);
                exp_rd_q.push_back(p == 1);
                exp_busy_q.push_back(p != 0);
                exp_done_q.push_back(1'b0);
                exp_cnt_q.push_back(cnt);
                c++;
            end
            for (int b = 0; b < FB; b++) begin
                if (b == 0) bitval = 1'b0;
                else if (b <= WIDTH) bitval = w[b-1];
                else if (PAR == 1 && b == WIDTH + 1) bitval = ^w;
                else bitval = 1'b1;
                for (int k = 0; k < BIT_DIV; k++) begin
                    last = (b == FB - 1) && (k == BIT_DIV - 1);
                    exp_q.push_back(bitval);
                    exp_rd_q.push_back(1'b0);
                    exp_busy_q.push_back(1'b1);
                    exp_done_q.push_back(last);
                    exp_cnt_q.push_back(cnt);
                    if (last) cnt = cnt + 8'd1;
                    c++;
                end
            end
        end
        for (int t = 0; t < tail; t++) begin
            exp_q.push_back(1'b1);
            exp_rd_q.push_back(1'b0);
            exp_busy_q.push_back(1'b0);
            exp_done_q.push_back(1'b0);
            exp_cnt_q.push_back(cnt);
        end
        model_count = cnt;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == drop_at) tx_enable = 1'b0;
            check("ser_out", 32'(ser_out), 32'(exp_q[i]));
            check("fifo_read", 32'(fifo_read), 32'(exp_rd_q[i]));
            check("busy", 32'(busy), 32'(exp_busy_q[i]));
            check("frame_done", 32'(frame_done), 32'(exp_done_q[i]));
            check("frame_count", 32'(frame_count), 32'(exp_cnt_q[i]));
            advance();
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [WIDTH-1:0] w1, w2;
        reset      = 1'b1;
        tx_enable  = 1'b0;
        fifo_empty = 1'b1;
        fifo_dout  = '0;
        advance();
        do_reset();

        // reset state
        check("rst_ser_out", 32'(ser_out), 32'd1);
        check("rst_fifo_read", 32'(fifo_read), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_state", 32'(debug_state), 32'(fifo_ser_pkg::ST_IDLE));

        // single known word
        push_word(16'hA5C3);
        tx_enable = 1'b1;
        rd_pulses = 0;
        busy_cycles = 0;
        run_frames(BIG, 8);
        check("a5c3_reads", 32'(rd_pulses), 32'd1);
        check("a5c3_span", 32'(busy_cycles), 32'(2 + FB * BIT_DIV));
        check("a5c3_count", 32'(frame_count), 32'd1);

        // parity corner words, back to back
        push_word(16'h0001);
        push_word(16'hA5C3);
        run_frames(BIG, 8);

        // three random words queued
        for (int i = 0; i < 3; i++) push_word(WIDTH'($urandom));
        rd_pulses = 0;
        run_frames(BIG, 8);
        check("three_reads", 32'(rd_pulses), 32'd3);
        check("three_count", 32'(frame_count), 32'(model_count));

        // tx_enable low holds off a non-empty FIFO
        tx_enable = 1'b0;
        push_word(WIDTH'($urandom));
        for (int i = 0; i < 20; i++) begin
            check("hold_read", 32'(fifo_read), 32'd0);
            check("hold_ser", 32'(ser_out), 32'd1);
            advance();
        end
        clear_fifo();

        // tx_enable dropped mid-frame: frame completes, no second read
        push_word(WIDTH'($urandom));
        push_word(WIDTH'($urandom));
        tx_enable = 1'b1;
        rd_pulses = 0;
        run_frames(40, 12);
        check("drop_reads", 32'(rd_pulses), 32'd1);
        clear_fifo();

        // reset in the 8th data bit
        do_reset();
        w1 = WIDTH'($urandom);
        w2 = WIDTH'($urandom);
        push_word(w1);
        push_word(w2);
        tx_enable = 1'b1;
        for (int i = 0; i < 3 + BIT_DIV + 7 * BIT_DIV + 1; i++) advance();
        check("bit7_ser", 32'(ser_out), 32'(w1[7]));
        reset = 1'b1;
        advance();
        check("mid_rst_ser", 32'(ser_out), 32'd1);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_count", 32'(frame_count), 32'd0);
        check("mid_rst_left", 32'(fifo_q.size()), 32'd1);
        reset = 1'b0;
        model_count = 8'd0;
        rd_pulses = 0;
        run_frames(BIG, 8);
        check("after_rst_reads", 32'(rd_pulses), 32'd1);

        // 256 frames: count wraps to 0
        do_reset();
        for (int i = 0; i < 256; i++) push_word(WIDTH'($urandom));
        rd_pulses = 0;
        run_frames(BIG, 4);
        check("wrap_reads", 32'(rd_pulses), 32'd256);
        check("wrap_count", 32'(frame_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
